// File: rtl/uart_hex_tracer_pkg.sv
// uart_hex_tracer_pkg: shared types and constants for the hex trace logger.
// Provides the formatter state enum, ASCII constants, field widths and the
// nibble-to-ASCII helper used by uart_hex_tracer.
package uart_hex_tracer_pkg;

  // Channel tag field width (up to 16 sources) and timestamp geometry.
  localparam int CH_W   = 4;
  localparam int TS_W   = 16;
  localparam int TS_NIB = TS_W / 4;

  localparam logic [7:0] CHR_COLON = 8'h3A;
  localparam logic [7:0] CHR_SPACE = 8'h20;
  localparam logic [7:0] CHR_CR    = 8'h0D;
  localparam logic [7:0] CHR_LF    = 8'h0A;

  typedef enum logic [2:0] {
    IDLE,
    TS,
    TAG,
    DATA,
    EOL
  } fmt_state_e;

  // Number of hex digits needed for a word of the given width.
  function automatic int nib_count(input int data_width);
    return data_width / 4;
  endfunction

  // Uppercase ASCII hex digit for a nibble.
  function automatic logic [7:0] hexdigit(input logic [3:0] nibble);
    if (nibble < 4'd10) begin
      return 8'h30 + {4'h0, nibble};
    end
    return 8'h37 + {4'h0, nibble};
  endfunction

endpackage

// File: rtl/trace_sync_fifo.sv
// trace_sync_fifo: single-clock FIFO holding captured trace entries.
// Latency: write visible at the head one cycle after push; read_data_o is the head, valid with pop_i.
// Backpressure: push while full is ignored unless pop_i is asserted in the same cycle.
// Ports: clk, rst_n (async active-low), push_i/wr_data_i, pop_i/read_data_o, full_o, empty_o.
module trace_sync_fifo #(
  parameter int WIDTH = 28,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] read_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             wr_ok, rd_ok;

  assign full_o      = (count_q == (AW+1)'(DEPTH));
  assign empty_o     = (count_q == '0);
  assign read_data_o = mem[rd_ptr_q];

  // A simultaneous pop frees the slot, so a full FIFO still takes the write.
  assign wr_ok = push_i && (!full_o || pop_i);
  assign rd_ok = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_ok) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/uart_hex_tracer.sv
// uart_hex_tracer: captures strobed words from CHANNELS sources and prints each as "C:HHHHHH\r\n".
// Latency: first byte strobes 2 cycles after the capture edge with uart_ready high.
// Backpressure: bytes issue only with uart_ready=1 and an idle cycle between strobes; FSM holds while uart_ready=0.
// Ports: clk, reset (async active-low), ch_strobe/ch_data (capture), uart_ready/uart_strobe/uart_data (byte out),
//        drop_count (saturating lost-word count), busy (FIFO non-empty or line in flight).
// Optional: define UART_HEX_TRACER_TIMESTAMP_EN to prefix each line with a 16-bit cycle timestamp "TTTT ".
module uart_hex_tracer
  import uart_hex_tracer_pkg::*;
#(
  parameter int CHANNELS   = 4,
  parameter int DATA_WIDTH = 24,
  parameter int DEPTH      = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [CHANNELS-1:0]            ch_strobe,
  input  logic [CHANNELS*DATA_WIDTH-1:0] ch_data,
  input  logic                           uart_ready,
  output logic                           uart_strobe,
  output logic [7:0]                     uart_data,
  output logic [7:0]                     drop_count,
  output logic                           busy
);

  localparam int NIB = nib_count(DATA_WIDTH);
`ifdef UART_HEX_TRACER_TIMESTAMP_EN
  localparam int ENTRY_W = TS_W + CH_W + DATA_WIDTH;
`else
  localparam int ENTRY_W = CH_W + DATA_WIDTH;
`endif

  // ---------------- capture arbitration and drop accounting ----------------
  logic                  win_any;
  logic [CH_W-1:0]       win_ch;
  logic [DATA_WIDTH-1:0] win_dat;
  logic [4:0]            n_req;
  logic [4:0]            n_drop;
  logic [8:0]            drop_sum;
  logic [7:0]            drop_q, drop_d;
  logic                  wr_ok;

  // Descending scan so the lowest asserted index is the last (winning) assignment.
  always_comb begin
    win_any = 1'b0;
    win_ch  = '0;
    win_dat = '0;
    n_req   = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (ch_strobe[i]) begin
        win_any = 1'b1;
        win_ch  = CH_W'(i);
        win_dat = ch_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    for (int i = 0; i < CHANNELS; i++) begin
      n_req = n_req + 5'(ch_strobe[i]);
    end
  end

  logic               fifo_full, fifo_empty, fifo_pop;
  logic [ENTRY_W-1:0] fifo_wdata, fifo_rdata;

  assign wr_ok    = win_any && (!fifo_full || fifo_pop);
  assign n_drop   = n_req - 5'(wr_ok);
  assign drop_sum = {1'b0, drop_q} + {4'h0, n_drop};
  assign drop_d   = (drop_sum > 9'd255) ? 8'hFF : drop_sum[7:0];

`ifdef UART_HEX_TRACER_TIMESTAMP_EN
  logic [TS_W-1:0] ts_cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ts_cnt_q <= '0;
    else        ts_cnt_q <= ts_cnt_q + 1'b1;
  end

  assign fifo_wdata = {ts_cnt_q, win_ch, win_dat};
`else
  assign fifo_wdata = {win_ch, win_dat};
`endif

  trace_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (reset),
    .push_i      (win_any),
    .wr_data_i   (fifo_wdata),
    .pop_i       (fifo_pop),
    .read_data_o (fifo_rdata),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  // ---------------- line formatter ----------------
  fmt_state_e            state_q, state_d;
  logic [4:0]            idx_q, idx_d;
  logic [DATA_WIDTH-1:0] sh_q, sh_d;
  logic [CH_W-1:0]       ch_q, ch_d;
  logic                  strobe_q, strobe_d;
  logic [7:0]            data_q, data_d;
  logic                  busy_q, busy_d;
  logic                  issue;
`ifdef UART_HEX_TRACER_TIMESTAMP_EN
  logic [TS_W-1:0]       ts_q, ts_d;
`endif

  // At most one strobe every other cycle: the previous strobe blocks this cycle.
  assign issue  = uart_ready && !strobe_q;
  assign busy_d = !(fifo_empty && (state_q == IDLE));

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    sh_d     = sh_q;
    ch_d     = ch_q;
    strobe_d = 1'b0;
    data_d   = data_q;
    fifo_pop = 1'b0;
`ifdef UART_HEX_TRACER_TIMESTAMP_EN
    ts_d     = ts_q;
`endif
    case (state_q)
      IDLE: begin
        if (uart_ready && !fifo_empty) begin
          fifo_pop = 1'b1;
          ch_d     = fifo_rdata[DATA_WIDTH +: CH_W];
          sh_d     = fifo_rdata[DATA_WIDTH-1:0];
          idx_d    = '0;
`ifdef UART_HEX_TRACER_TIMESTAMP_EN
          ts_d     = fifo_rdata[ENTRY_W-1 -: TS_W];
          state_d  = TS;
`else
          state_d  = TAG;
`endif
        end
      end
      TS: begin
`ifdef UART_HEX_TRACER_TIMESTAMP_EN
        if (issue) begin
          strobe_d = 1'b1;
          if (idx_q == 5'(TS_NIB)) begin
            data_d  = CHR_SPACE;
            idx_d   = '0;
            state_d = TAG;
          end else begin
            data_d = hexdigit(ts_q[TS_W-1 -: 4]);
            ts_d   = ts_q << 4;
            idx_d  = idx_q + 1'b1;
          end
        end
`else
        state_d = IDLE;
`endif
      end
      TAG: begin
        if (issue) begin
          strobe_d = 1'b1;
          if (idx_q == '0) begin
            data_d = hexdigit(ch_q);
            idx_d  = 5'd1;
          end else begin
            data_d  = CHR_COLON;
            idx_d   = '0;
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (issue) begin
          strobe_d = 1'b1;
          data_d   = hexdigit(sh_q[DATA_WIDTH-1 -: 4]);
          sh_d     = sh_q << 4;
          if (idx_q == 5'(NIB - 1)) begin
            idx_d   = '0;
            state_d = EOL;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      EOL: begin
        if (issue) begin
          strobe_d = 1'b1;
          if (idx_q == '0) begin
            data_d = CHR_CR;
            idx_d  = 5'd1;
          end else begin
            data_d  = CHR_LF;
            idx_d   = '0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      sh_q     <= '0;
      ch_q     <= '0;
      strobe_q <= 1'b0;
      data_q   <= '0;
      drop_q   <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      sh_q     <= sh_d;
      ch_q     <= ch_d;
      strobe_q <= strobe_d;
      data_q   <= data_d;
      drop_q   <= drop_d;
      busy_q   <= busy_d;
    end
  end

`ifdef UART_HEX_TRACER_TIMESTAMP_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ts_q <= '0;
    else        ts_q <= ts_d;
  end
`endif

  assign uart_strobe = strobe_q;
  assign uart_data   = data_q;
  assign drop_count  = drop_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_uart_hex_tracer.sv
module tb_uart_hex_tracer;

  localparam int CH    = 4;
  localparam int DW    = 24;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [CH-1:0]    ch_strobe = '0;
  logic [CH*DW-1:0] ch_data = '0;
  logic             uart_ready = 1'b0;
  logic             uart_strobe;
  logic [7:0]       uart_data;
  logic [7:0]       drop_count;
  logic             busy;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_drop = 0;
  logic [7:0] exp_q[$];
  logic prev_strobe = 1'b0;

  always #5 clk = ~clk;

  uart_hex_tracer #(.CHANNELS(CH), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .ch_strobe   (ch_strobe),
    .ch_data     (ch_data),
    .uart_ready  (uart_ready),
    .uart_strobe (uart_strobe),
    .uart_data   (uart_data),
    .drop_count  (drop_count),
    .busy        (busy)
  );

`ifdef UART_HEX_TRACER_TIMESTAMP_EN
  // Reference cycle counter: value at a negedge equals the timestamp a capture on the next edge records.
  logic [15:0] cyc;
  always @(posedge clk or negedge reset) begin
    if (!reset) cyc <= 16'h0;
    else        cyc <= cyc + 16'h1;
  end
`endif

  // Byte monitor / scoreboard consumer.
  always @(negedge clk) begin
    if (!reset) begin
      prev_strobe = 1'b0;
    end else begin
      if (uart_strobe) begin
        n_checks++;
        if (prev_strobe) begin
          n_fail++;
          $display("FAIL strobe_spacing: strobe high on consecutive cycles, required an idle cycle");
        end
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_byte: got 0x%02h with nothing expected", uart_data);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          if (uart_data !== e) begin
            n_fail++;
            $display("FAIL byte: got 0x%02h required 0x%02h", uart_data, e);
          end
        end
      end
      prev_strobe = uart_strobe;
    end
  end

  function automatic logic [7:0] hx(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    return 8'h41 + {4'h0, n} - 8'd10;
  endfunction

  task automatic push_str(input string s);
    for (int i = 0; i < s.len(); i++) exp_q.push_back(8'(s[i]));
  endtask

  task automatic push_prefix();
`ifdef UART_HEX_TRACER_TIMESTAMP_EN
    for (int n = 3; n >= 0; n--) exp_q.push_back(hx(cyc[n*4 +: 4]));
    exp_q.push_back(8'h20);
`endif
  endtask

  task automatic push_eol();
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  task automatic push_line(input int ch, input logic [23:0] d);
    push_prefix();
    exp_q.push_back(hx(4'(ch)));
    exp_q.push_back(8'h3A);
    for (int n = 5; n >= 0; n--) exp_q.push_back(hx(d[n*4 +: 4]));
    push_eol();
  endtask

  task automatic wait_idle(input int budget, input string tag);
    bit done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      #1;
      if (exp_q.size() == 0 && busy === 1'b0 && uart_strobe === 1'b0) done = 1'b1;
    end
    n_checks++;
    if (!done) begin
      n_fail++;
      $display("FAIL %s_drain: %0d bytes pending busy=%b, required 0 pending busy=0", tag, exp_q.size(), busy);
    end
  endtask

  task automatic check_drop(input string tag);
    n_checks++;
    if (drop_count !== 8'(exp_drop)) begin
      n_fail++;
      $display("FAIL %s_drop: drop_count=%0d required %0d", tag, drop_count, exp_drop);
    end
  endtask

  task automatic wait_remaining(input int rem, input string tag);
    bit done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      #1;
      if (exp_q.size() <= rem) done = 1'b1;
    end
    n_checks++;
    if (!done) begin
      n_fail++;
      $display("FAIL %s_progress: %0d bytes pending, required <= %0d", tag, exp_q.size(), rem);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (uart_strobe !== 1'b0) begin n_fail++; $display("FAIL reset_strobe: got %b required 0", uart_strobe); end
    n_checks++; if (uart_data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got 0x%02h required 0x00", uart_data); end
    n_checks++; if (drop_count !== 8'h00) begin n_fail++; $display("FAIL reset_drop: got %0d required 0", drop_count); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b required 0", busy); end
    reset = 1'b1;
    exp_drop = 0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int k;
    uart_ready = 1'b1;
    @(negedge clk);
    ch_strobe[2] = 1'b1;
    ch_data[2*DW +: DW] = 24'hA1B2C3;
    push_prefix();
    push_str("2:A1B2C3");
    push_eol();
    @(negedge clk);
    ch_strobe = '0;
    k = 0;
    while (uart_strobe !== 1'b1 && k < 10) begin
      @(negedge clk);
      k++;
    end
    n_checks++; if (k != 2) begin n_fail++; $display("FAIL basic_latency: first byte %0d cycles after capture, required 2", k); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy: got %b required 1 during line", busy); end
    wait_idle(60, "basic");
    check_drop("basic");
  endtask

  task automatic test_same_cycle();
    uart_ready = 1'b1;
    @(negedge clk);
    ch_strobe = 4'b1001;
    ch_data[0 +: DW]    = 24'h000001;
    ch_data[3*DW +: DW] = 24'hFFFFFF;
    push_prefix();
    push_str("0:000001");
    push_eol();
    exp_drop += 1;
    @(negedge clk);
    ch_strobe = '0;
    check_drop("same_cycle");
    wait_idle(60, "same_cycle");
  endtask

  task automatic test_fifo_full();
    int sz;
    uart_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      ch_strobe = 4'b0010;
      ch_data[DW +: DW] = 24'h100000 + 24'(i);
      if (i < DEPTH) push_line(1, 24'h100000 + 24'(i));
    end
    @(negedge clk);
    ch_strobe = '0;
    exp_drop += 2;
    sz = exp_q.size();
    check_drop("fifo_full");
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL full_busy: got %b required 1", busy); end
    repeat (10) @(negedge clk);
    #1;
    n_checks++; if (exp_q.size() != sz) begin n_fail++; $display("FAIL full_hold: %0d bytes emitted with uart_ready low, required 0", sz - exp_q.size()); end
    uart_ready = 1'b1;
    wait_idle(300, "fifo_full");
  endtask

  task automatic test_stall();
    int cnt;
    uart_ready = 1'b1;
    @(negedge clk);
    ch_strobe = 4'b1000;
    ch_data[3*DW +: DW] = 24'h0F1E2D;
    push_line(3, 24'h0F1E2D);
    @(negedge clk);
    ch_strobe = '0;
    wait_remaining(5, "stall");
    uart_ready = 1'b0;
    cnt = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (uart_strobe === 1'b1) cnt++;
    end
    n_checks++; if (cnt != 0) begin n_fail++; $display("FAIL stall_quiet: %0d strobes while stalled, required 0", cnt); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL stall_busy: got %b required 1", busy); end
    uart_ready = 1'b1;
    wait_idle(100, "stall");
  endtask

  task automatic test_back_to_back();
    int ch;
    logic [23:0] d;
    uart_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      ch = $urandom_range(0, CH - 1);
      d  = 24'($urandom);
      ch_strobe = 4'(1 << ch);
      ch_data[ch*DW +: DW] = d;
      push_line(ch, d);
    end
    @(negedge clk);
    ch_strobe = '0;
    wait_idle(400, "back_to_back");
    check_drop("back_to_back");
  endtask

  task automatic test_drop_saturation();
    uart_ready = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      ch_strobe = 4'hF;
      ch_data = {4{24'(i)}};
      if (i < DEPTH) push_line(0, 24'(i));
      exp_drop = exp_drop + 3 + ((i >= DEPTH) ? 1 : 0);
      if (exp_drop > 255) exp_drop = 255;
    end
    @(negedge clk);
    ch_strobe = '0;
    check_drop("saturation");
    uart_ready = 1'b1;
    wait_idle(300, "saturation");
  endtask

  task automatic test_reset_midline();
    int cnt;
    uart_ready = 1'b1;
    @(negedge clk);
    ch_strobe = 4'b0100;
    ch_data[2*DW +: DW] = 24'hABCDEF;
    push_line(2, 24'hABCDEF);
    @(negedge clk);
    ch_strobe = '0;
    wait_remaining(6, "midline");
    @(posedge clk);
    #2;
    reset = 1'b0;
    exp_q.delete();
    exp_drop = 0;
    #1;
    n_checks++; if (uart_strobe !== 1'b0) begin n_fail++; $display("FAIL async_reset_strobe: got %b required 0", uart_strobe); end
    n_checks++; if (drop_count !== 8'h00) begin n_fail++; $display("FAIL async_reset_drop: got %0d required 0", drop_count); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL async_reset_busy: got %b required 0", busy); end
    @(negedge clk);
    @(negedge clk);
    #2;
    reset = 1'b1;
    cnt = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (uart_strobe === 1'b1) cnt++;
    end
    n_checks++; if (cnt != 0) begin n_fail++; $display("FAIL after_reset_quiet: %0d bytes after release, required 0", cnt); end
    @(negedge clk);
    ch_strobe = 4'b0010;
    ch_data[DW +: DW] = 24'h000ABC;
    push_line(1, 24'h000ABC);
    @(negedge clk);
    ch_strobe = '0;
    wait_idle(100, "after_reset");
    check_drop("after_reset");
  endtask

`ifdef UART_HEX_TRACER_TIMESTAMP_EN
  task automatic test_timestamp();
    uart_ready = 1'b1;
    ch_strobe = '0;
    reset = 1'b0;
    exp_q.delete();
    exp_drop = 0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    repeat (255) @(negedge clk);
    ch_strobe = 4'b0010;
    ch_data[DW +: DW] = 24'h123456;
    push_str("00FF 1:123456");
    push_eol();
    @(negedge clk);
    ch_strobe = '0;
    wait_idle(100, "timestamp");
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_same_cycle();
    test_fifo_full();
    test_stall();
    test_back_to_back();
    test_drop_saturation();
    test_reset_midline();
`ifdef UART_HEX_TRACER_TIMESTAMP_EN
    test_timestamp();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
